// File: rtl/uart_cfg_pkg.sv
// ============================================================================
//  Module   : uart_cfg_pkg
//  Purpose  : Shared constants for the UART configuration register file:
//             register offsets, register count, reset values and FSM states.
//  Macro    : UART_REGFILE_LOCK_EN adds the lock register at offset 5.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cfg_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [2:0] OFF_PARITY      = 3'd0;
    localparam logic [2:0] OFF_PARITY_TYPE = 3'd1;
    localparam logic [2:0] OFF_STOP_BITS   = 3'd2;
    localparam logic [2:0] OFF_FRAME_LEN   = 3'd3;
    localparam logic [2:0] OFF_BAUD_SEL    = 3'd4;
    localparam logic [2:0] OFF_LOCK        = 3'd5;

`ifdef UART_REGFILE_LOCK_EN
    localparam int NUM_REGS = 6;
`else
    localparam int NUM_REGS = 5;
`endif

    // Reset values
    localparam logic       RST_PARITY      = 1'b1;
    localparam logic       RST_PARITY_TYPE = 1'b0;
    localparam logic       RST_STOP_BITS   = 1'b0;
    localparam logic [3:0] RST_FRAME_LEN   = 4'd8;
    localparam logic [3:0] RST_BAUD_SEL    = 4'd0;
    localparam logic       RST_LOCK        = 1'b0;

    // Transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_cfg_regfile.sv
// ============================================================================
//  Module   : uart_cfg_regfile
//  Purpose  : UART frame-format / baud-select configuration register file with
//             a one-cycle ack per command, error flag and range checking.
//  Ports    : clk_16bd, rst            - clock, synchronous active-high reset
//             valid_i/wr_i/address_i/data_i - command request (level, held)
//             ack_o/err_o/rdata_o/rdata_valid_o - one-cycle response
//             parity_o, parity_type_o, stop_bits_o, frame_length_o,
//             baud_sel_o                - configuration fields
//             cfg_changed_o             - pulse after any field value change
//  Macro    : UART_REGFILE_LOCK_EN - lock register at offset 5 blocks writes
//             to offsets 0-4 while set.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cfg_regfile
    import uart_cfg_pkg::*;
#(
    parameter int                DATA_W    = 4,
    parameter int                ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h9,
    parameter int                FL_MIN    = 5,
    parameter int                FL_MAX    = 9
) (
    input  logic              clk_16bd,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              parity_o,
    output logic              parity_type_o,
    output logic              stop_bits_o,
    output logic [3:0]        frame_length_o,
    output logic [3:0]        baud_sel_o,
    output logic              cfg_changed_o
);

    state_e            state_q, state_d;
    logic              parity_q, parity_d;
    logic              ptype_q, ptype_d;
    logic              stop_q, stop_d;
    logic [3:0]        flen_q, flen_d;
    logic [3:0]        baud_q, baud_d;
    logic              lock_q, lock_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              chg_q, chg_d;

    // Offset computed one bit wider so addresses below BASE_ADDR show up as
    // negative (MSB set) instead of wrapping onto a valid register.
    logic [ADDR_W:0]   w_off;
    logic              w_mapped;
    logic [2:0]        w_idx;
    logic              w_flen_ok;
    logic              w_locked;
    logic              w_unused;

    assign w_off     = {1'b0, address_i} - {1'b0, BASE_ADDR};
    assign w_mapped  = ~w_off[ADDR_W] && (w_off < (ADDR_W+1)'(NUM_REGS));
    assign w_idx     = w_off[2:0];
    assign w_flen_ok = (data_i[3:0] >= 4'(FL_MIN)) && (data_i[3:0] <= 4'(FL_MAX));
    // Only the low nibble of the write data is ever stored.
    assign w_unused  = ^data_i;

`ifdef UART_REGFILE_LOCK_EN
    // The lock bit itself stays writable so software can always unlock.
    assign w_locked = lock_q && (w_idx != OFF_LOCK);
`else
    assign w_locked = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q;
        ptype_d  = ptype_q;
        stop_d   = stop_q;
        flen_d   = flen_q;
        baud_d   = baud_q;
        lock_d   = lock_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    if (!w_mapped) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!wr_i) begin
                        rvalid_d = 1'b1;
                        case (w_idx)
                            OFF_PARITY:      rdata_d = DATA_W'(parity_q);
                            OFF_PARITY_TYPE: rdata_d = DATA_W'(ptype_q);
                            OFF_STOP_BITS:   rdata_d = DATA_W'(stop_q);
                            OFF_FRAME_LEN:   rdata_d = DATA_W'(flen_q);
                            OFF_BAUD_SEL:    rdata_d = DATA_W'(baud_q);
                            OFF_LOCK:        rdata_d = DATA_W'(lock_q);
                            default:         rdata_d = '0;
                        endcase
                    end else if (w_locked) begin
                        err_d = 1'b1;
                    end else begin
                        case (w_idx)
                            OFF_PARITY:      parity_d = data_i[0];
                            OFF_PARITY_TYPE: ptype_d  = data_i[0];
                            OFF_STOP_BITS:   stop_d   = data_i[0];
                            OFF_FRAME_LEN: begin
                                if (w_flen_ok) flen_d = data_i[3:0];
                                else           err_d  = 1'b1;
                            end
                            OFF_BAUD_SEL:    baud_d   = data_i[3:0];
                            OFF_LOCK:        lock_d   = data_i[0];
                            default:         err_d    = 1'b1;
                        endcase
                    end
                end
            end
            ST_RESP: state_d = valid_i ? ST_HOLD : ST_IDLE;
            ST_HOLD: if (!valid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        chg_d = {parity_d, ptype_d, stop_d, flen_d, baud_d, lock_d}
             != {parity_q, ptype_q, stop_q, flen_q, baud_q, lock_q};
    end

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            parity_q <= RST_PARITY;
            ptype_q  <= RST_PARITY_TYPE;
            stop_q   <= RST_STOP_BITS;
            flen_q   <= RST_FRAME_LEN;
            baud_q   <= RST_BAUD_SEL;
            lock_q   <= RST_LOCK;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            ptype_q  <= ptype_d;
            stop_q   <= stop_d;
            flen_q   <= flen_d;
            baud_q   <= baud_d;
            lock_q   <= lock_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            chg_q    <= chg_d;
        end
    end

    assign ack_o          = ack_q;
    assign err_o          = err_q;
    assign rdata_o        = rdata_q;
    assign rdata_valid_o  = rvalid_q;
    assign parity_o       = parity_q;
    assign parity_type_o  = ptype_q;
    assign stop_bits_o    = stop_q;
    assign frame_length_o = flen_q;
    assign baud_sel_o     = baud_q;
    assign cfg_changed_o  = chg_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cfg_regfile.sv
// ============================================================================
//  Module   : tb_uart_cfg_regfile
//  Purpose  : Self-checking bench for uart_cfg_regfile. A driver issues
//             commands and pushes the reference model's expected response
//             into a queue; a monitor pops and compares on every ack.
//  Macro    : UART_REGFILE_LOCK_EN enables the lock scenario and lock model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cfg_regfile;

    localparam int DATA_W = 8;
`ifdef UART_REGFILE_LOCK_EN
    localparam int NREG = 6;
`else
    localparam int NREG = 5;
`endif

    typedef struct {
        logic              err;
        logic              rv;
        logic [DATA_W-1:0] rdata;
        logic              chg;
        logic [10:0]       fields;
    } exp_t;

    logic              clk_16bd = 1'b0;
    logic              rst = 1'b1;
    logic              valid_i = 1'b0;
    logic              wr_i = 1'b0;
    logic [3:0]        address_i = '0;
    logic [DATA_W-1:0] data_i = '0;
    logic              ack_o, err_o, rdata_valid_o, cfg_changed_o;
    logic [DATA_W-1:0] rdata_o;
    logic              parity_o, parity_type_o, stop_bits_o;
    logic [3:0]        frame_length_o, baud_sel_o;

    uart_cfg_regfile #(
        .DATA_W(DATA_W), .ADDR_W(4), .BASE_ADDR(4'h9), .FL_MIN(5), .FL_MAX(9)
    ) dut (
        .clk_16bd(clk_16bd), .rst(rst), .valid_i(valid_i), .wr_i(wr_i),
        .address_i(address_i), .data_i(data_i), .ack_o(ack_o), .err_o(err_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .parity_o(parity_o),
        .parity_type_o(parity_type_o), .stop_bits_o(stop_bits_o),
        .frame_length_o(frame_length_o), .baud_sel_o(baud_sel_o),
        .cfg_changed_o(cfg_changed_o)
    );

    always #5 clk_16bd = ~clk_16bd;

    int   checks = 0;
    int   failures = 0;
    int   ack_count = 0;
    exp_t q[$];

    // Reference model: register contents by offset plus the last read value.
    int m_reg[0:5];
    int m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_reg[0] = 1; m_reg[1] = 0; m_reg[2] = 0;
        m_reg[3] = 8; m_reg[4] = 0; m_reg[5] = 0;
        m_rdata  = 0;
    endtask

    function automatic logic [10:0] model_fields();
        int p = m_reg[0], t = m_reg[1], s = m_reg[2], f = m_reg[3], b = m_reg[4];
        return {p[0], t[0], s[0], f[3:0], b[3:0]};
    endfunction

    function automatic logic [10:0] dut_fields();
        return {parity_o, parity_type_o, stop_bits_o, frame_length_o, baud_sel_o};
    endfunction

    task automatic model_exec(input logic wr, input logic [3:0] addr,
                              input logic [DATA_W-1:0] data, output exp_t e);
        int off = int'(addr) - 9;
        int old[0:5];
        int v;
        for (int i = 0; i < 6; i++) old[i] = m_reg[i];
        e.err = 1'b0;
        e.rv  = 1'b0;
        if (off < 0 || off >= NREG) begin
            e.err   = 1'b1;
            m_rdata = 0;
        end else if (!wr) begin
            m_rdata = m_reg[off];
            e.rv    = 1'b1;
        end else if (NREG == 6 && m_reg[5] == 1 && off != 5) begin
            e.err = 1'b1;
        end else if (off == 3) begin
            v = int'(data) % 16;
            if (v < 5 || v > 9) e.err = 1'b1;
            else                m_reg[3] = v;
        end else if (off == 4) begin
            m_reg[4] = int'(data) % 16;
        end else begin
            m_reg[off] = int'(data) % 2;
        end
        e.chg = 1'b0;
        for (int i = 0; i < 6; i++) if (old[i] != m_reg[i]) e.chg = 1'b1;
        e.rdata  = DATA_W'(m_rdata);
        e.fields = model_fields();
    endtask

    // Monitor: compares each ack against the oldest queued expectation.
    initial begin : monitor
        logic prev_ack = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk_16bd);
            #1;
            if (ack_o) begin
                ack_count++;
                if (prev_ack) chk("ack_one_cycle", 32'(ack_o), 32'(1'b0));
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack actual=1 required=0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("err", 32'(err_o), 32'(e.err));
                    chk("rdata_valid", 32'(rdata_valid_o), 32'(e.rv));
                    chk("rdata", 32'(rdata_o), 32'(e.rdata));
                    chk("cfg_changed", 32'(cfg_changed_o), 32'(e.chg));
                    chk("fields", 32'(dut_fields()), 32'(e.fields));
                end
            end else if (!rst && (err_o || rdata_valid_o || cfg_changed_o)) begin
                checks++;
                failures++;
                $display("FAIL stray_pulse actual=%b%b%b required=000 at %0t",
                         err_o, rdata_valid_o, cfg_changed_o, $time);
            end
            prev_ack = ack_o;
        end
    end

    task automatic wait_ack(input int start);
        for (int i = 0; i < 10 && ack_count == start; i++) begin
            @(posedge clk_16bd);
            #2;
        end
        if (ack_count == start) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=none required=ack at %0t", $time);
            q.delete();
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [3:0] addr,
                          input logic [DATA_W-1:0] data, input int hold);
        exp_t e;
        int   start;
        model_exec(wr, addr, data, e);
        q.push_back(e);
        valid_i   = 1'b1;
        wr_i      = wr;
        address_i = addr;
        data_i    = data;
        start     = ack_count;
        wait_ack(start);
        repeat (hold) begin
            @(posedge clk_16bd);
            #2;
        end
        valid_i = 1'b0;
        @(posedge clk_16bd);
        #2;
    endtask

    initial begin : driver
        exp_t e;
        int   start;
        model_reset();
        repeat (3) @(posedge clk_16bd);
        #2;
        rst = 1'b0;

        // Reset state
        chk("rst_ack", 32'(ack_o), 0);
        chk("rst_rdata", 32'(rdata_o), 0);
        chk("rst_fields", 32'(dut_fields()), 32'(model_fields()));

        // Read back reset values at addresses 9..13
        for (int a = 9; a <= 13; a++) do_cmd(1'b0, 4'(a), 8'hFF, 0);

        // frame_length: legal write, read, rewrite same value
        do_cmd(1'b1, 4'd12, 8'hF7, 0);
        do_cmd(1'b0, 4'd12, 8'h00, 0);
        do_cmd(1'b1, 4'd12, 8'h07, 0);
        // Illegal frame_length, boundaries, unmapped addresses
        do_cmd(1'b1, 4'd12, 8'h0C, 0);
        do_cmd(1'b1, 4'd3,  8'h01, 0);
        do_cmd(1'b0, 4'd3,  8'h00, 0);
        do_cmd(1'b1, 4'd12, 8'h04, 0);
        do_cmd(1'b1, 4'd12, 8'h0A, 0);
        do_cmd(1'b1, 4'd12, 8'h05, 0);
        do_cmd(1'b1, 4'd12, 8'h09, 0);
        do_cmd(1'b0, 4'd12, 8'h00, 0);
        do_cmd(1'b0, 4'd15, 8'h00, 0);

        // Valid held for 6 cycles: exactly one execution
        start = ack_count;
        do_cmd(1'b1, 4'd9, 8'h00, 6);
        chk("hold_single_ack", 32'(ack_count - start), 1);
        do_cmd(1'b0, 4'd9, 8'h00, 0);

        // Reset while in RESP, valid kept high -> re-executes once
        model_exec(1'b1, 4'd13, 8'h05, e);
        q.push_back(e);
        valid_i = 1'b1; wr_i = 1'b1; address_i = 4'd13; data_i = 8'h05;
        start = ack_count;
        wait_ack(start);
        rst = 1'b1;
        model_reset();
        @(posedge clk_16bd);
        #2;
        chk("rst_resp_ack", 32'(ack_o), 0);
        chk("rst_resp_fields", 32'(dut_fields()), 32'(model_fields()));
        chk("rst_resp_rdata", 32'(rdata_o), 0);
        rst = 1'b0;
        model_exec(1'b1, 4'd13, 8'h05, e);
        q.push_back(e);
        start = ack_count;
        wait_ack(start);
        valid_i = 1'b0;
        @(posedge clk_16bd);
        #2;
        chk("rst_reexec_once", 32'(ack_count - start), 1);

`ifdef UART_REGFILE_LOCK_EN
        do_cmd(1'b1, 4'd13, 8'h00, 0);
        do_cmd(1'b1, 4'd14, 8'h01, 0);
        do_cmd(1'b1, 4'd13, 8'h03, 0);
        do_cmd(1'b0, 4'd14, 8'h00, 0);
        do_cmd(1'b1, 4'd14, 8'h00, 0);
        do_cmd(1'b1, 4'd13, 8'h03, 0);
        do_cmd(1'b0, 4'd13, 8'h00, 0);
`else
        do_cmd(1'b1, 4'd14, 8'h01, 0);
        do_cmd(1'b0, 4'd14, 8'h00, 0);
`endif

        // Randomized commands, biased toward mapped addresses
        for (int n = 0; n < 120; n++) begin
            logic [3:0] a;
            if ($urandom_range(3, 0) != 0) a = 4'($urandom_range(14, 9));
            else                           a = 4'($urandom_range(15, 0));
            do_cmd(1'($urandom_range(1, 0)), a, 8'($urandom), int'($urandom_range(3, 0)));
        end

        repeat (3) @(posedge clk_16bd);
        #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
